// File: rtl/ex_mem_pkg.sv
// Shared types and constants for the EX/MEM boundary register.
package ex_mem_pkg;

  localparam int EM_DATA_W     = 32;
  localparam int EM_REG_ADDR_W = 4;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef struct packed {
    logic [EM_DATA_W-1:0]     alu_result;
    logic [EM_DATA_W-1:0]     st_val;
    logic [EM_REG_ADDR_W-1:0] dest;
    logic                     wb_en;
    logic                     mem_r_en;
    logic                     mem_w_en;
  } ex_mem_entry_t;

  // Encoding is {main_valid, skid_valid}; 2'b01 is unreachable.
  typedef enum logic [1:0] {
    SB_EMPTY = 2'b00,
    SB_ONE   = 2'b10,
    SB_FULL  = 2'b11
  } sb_state_t;

endpackage

// File: rtl/ex_mem_skid_buf.sv
// Two-entry valid/ready skid buffer with synchronous flush; o_ready is decoded
// from state only, so back-pressure never forms a combinational path upstream.
module ex_mem_skid_buf
  import ex_mem_pkg::*;
#(
  parameter type T = ex_mem_entry_t
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_flush,
  input  logic i_valid,
  output logic o_ready,
  input  T     i_data,
  output logic o_valid,
  input  logic i_ready,
  output T     o_data
);

  sb_state_t r_state, w_state_nxt;
  T          r_main, r_skid;
  logic      w_in_fire, w_out_fire;
  logic      w_ld_main_in, w_ld_main_skid, w_ld_skid;

  assign o_valid    = (r_state != SB_EMPTY);
  assign o_ready    = (r_state != SB_FULL);
  assign o_data     = r_main;
  assign w_in_fire  = i_valid & o_ready;
  assign w_out_fire = o_valid & i_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= SB_EMPTY;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_ld_main_in   = 1'b0;
    w_ld_main_skid = 1'b0;
    w_ld_skid      = 1'b0;
    if (i_flush) begin
      w_state_nxt = SB_EMPTY;
    end else begin
      case (r_state)
        SB_EMPTY: begin
          if (w_in_fire) begin
            w_state_nxt  = SB_ONE;
            w_ld_main_in = 1'b1;
          end
        end
        SB_ONE: begin
          if (w_in_fire && w_out_fire) begin
            w_ld_main_in = 1'b1;
          end else if (w_in_fire) begin
            w_state_nxt = SB_FULL;
            w_ld_skid   = 1'b1;
          end else if (w_out_fire) begin
            w_state_nxt = SB_EMPTY;
          end
        end
        SB_FULL: begin
          if (w_out_fire) begin
            w_state_nxt    = SB_ONE;
            w_ld_main_skid = 1'b1;
          end
        end
        default: w_state_nxt = SB_EMPTY;
      endcase
    end
  end

  // Payload is left stale on flush/drain; consumers qualify it with o_valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_main <= '0;
      r_skid <= '0;
    end else begin
      if (w_ld_main_in)        r_main <= i_data;
      else if (w_ld_main_skid) r_main <= r_skid;
      if (w_ld_skid)           r_skid <= i_data;
    end
  end

endmodule

// File: rtl/ex_mem_stage_reg.sv
// EX/MEM pipeline register: skid-buffered entry path plus the NZCV status register.
// Optional forwarding taps are enabled by defining EX_MEM_FWD_EN.
module ex_mem_stage_reg
  import ex_mem_pkg::*;
#(
  // Must match the entry struct widths in ex_mem_pkg.
  parameter int DATA_W     = EM_DATA_W,
  parameter int REG_ADDR_W = EM_REG_ADDR_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_W-1:0]     in_alu_result,
  input  logic [DATA_W-1:0]     in_st_val,
  input  logic [REG_ADDR_W-1:0] in_dest,
  input  logic                  in_wb_en,
  input  logic                  in_mem_r_en,
  input  logic                  in_mem_w_en,
  input  logic                  in_s_en,
  input  logic [3:0]            in_flags,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_W-1:0]     out_alu_result,
  output logic [DATA_W-1:0]     out_st_val,
  output logic [REG_ADDR_W-1:0] out_dest,
  output logic                  out_wb_en,
  output logic                  out_mem_r_en,
  output logic                  out_mem_w_en,
`ifdef EX_MEM_FWD_EN
  output logic                  fwd_valid,
  output logic [REG_ADDR_W-1:0] fwd_dest,
  output logic [DATA_W-1:0]     fwd_value,
`endif
  output logic [3:0]            status
);

  ex_mem_entry_t w_in_ent, w_head;
  logic          w_in_fire;
  logic [3:0]    r_status;

  assign w_in_ent.alu_result = in_alu_result;
  assign w_in_ent.st_val     = in_st_val;
  assign w_in_ent.dest       = in_dest;
  assign w_in_ent.wb_en      = in_wb_en;
  assign w_in_ent.mem_r_en   = in_mem_r_en;
  assign w_in_ent.mem_w_en   = in_mem_w_en;

  ex_mem_skid_buf #(.T(ex_mem_entry_t)) u_skid (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_flush (flush),
    .i_valid (in_valid),
    .o_ready (in_ready),
    .i_data  (w_in_ent),
    .o_valid (out_valid),
    .i_ready (out_ready),
    .o_data  (w_head)
  );

  assign out_alu_result = w_head.alu_result;
  assign out_st_val     = w_head.st_val;
  assign out_dest       = w_head.dest;
  assign out_wb_en      = w_head.wb_en;
  assign out_mem_r_en   = w_head.mem_r_en;
  assign out_mem_w_en   = w_head.mem_w_en;

  // Flags commit at acceptance; a squashed entry never touches status.
  assign w_in_fire = in_valid & in_ready & ~flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                   r_status <= 4'b0000;
    else if (w_in_fire && in_s_en) r_status <= in_flags;
  end

  assign status = r_status;

`ifdef EX_MEM_FWD_EN
  // Loads are excluded: their value is not known until MEM completes.
  assign fwd_valid = out_valid & w_head.wb_en & ~w_head.mem_r_en;
  assign fwd_dest  = fwd_valid ? w_head.dest       : '0;
  assign fwd_value = fwd_valid ? w_head.alu_result : '0;
`endif

endmodule

// File: tb/tb_ex_mem_stage_reg.sv
// Bench for ex_mem_stage_reg: queue model checked every cycle plus directed literals.
module tb_ex_mem_stage_reg;
  import ex_mem_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_alu_result = '0;
  logic [31:0] in_st_val = '0;
  logic [3:0]  in_dest = '0;
  logic        in_wb_en = 1'b0, in_mem_r_en = 1'b0, in_mem_w_en = 1'b0;
  logic        in_s_en = 1'b0;
  logic [3:0]  in_flags = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_alu_result, out_st_val;
  logic [3:0]  out_dest;
  logic        out_wb_en, out_mem_r_en, out_mem_w_en;
  logic [3:0]  status;
`ifdef EX_MEM_FWD_EN
  logic        fwd_valid;
  logic [3:0]  fwd_dest;
  logic [31:0] fwd_value;
`endif

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  ex_mem_stage_reg dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_alu_result(in_alu_result), .in_st_val(in_st_val), .in_dest(in_dest),
    .in_wb_en(in_wb_en), .in_mem_r_en(in_mem_r_en), .in_mem_w_en(in_mem_w_en),
    .in_s_en(in_s_en), .in_flags(in_flags),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_alu_result(out_alu_result), .out_st_val(out_st_val), .out_dest(out_dest),
    .out_wb_en(out_wb_en), .out_mem_r_en(out_mem_r_en), .out_mem_w_en(out_mem_w_en),
`ifdef EX_MEM_FWD_EN
    .fwd_valid(fwd_valid), .fwd_dest(fwd_dest), .fwd_value(fwd_value),
`endif
    .status(status)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: an in-order queue of at most two entries plus a flags register.
  ex_mem_entry_t mq[$];
  logic [3:0]    m_status = 4'h0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      m_status = 4'h0;
    end else if (flush) begin
      mq.delete();
    end else begin
      ex_mem_entry_t e;
      bit rdy, ofire, ifire;
      rdy   = (mq.size() < 2);
      ofire = (mq.size() != 0) && out_ready;
      ifire = in_valid && rdy;
      e.alu_result = in_alu_result;
      e.st_val     = in_st_val;
      e.dest       = in_dest;
      e.wb_en      = in_wb_en;
      e.mem_r_en   = in_mem_r_en;
      e.mem_w_en   = in_mem_w_en;
      if (ifire && in_s_en) m_status = in_flags;
      if (ofire) void'(mq.pop_front());
      if (ifire) mq.push_back(e);
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("out_valid", 64'(out_valid), 64'(mq.size() != 0));
      chk("in_ready",  64'(in_ready),  64'(mq.size() < 2));
      chk("status",    64'(status),    64'(m_status));
      if (mq.size() != 0) begin
        chk("out_alu_result", 64'(out_alu_result), 64'(mq[0].alu_result));
        chk("out_st_val",     64'(out_st_val),     64'(mq[0].st_val));
        chk("out_dest",       64'(out_dest),       64'(mq[0].dest));
        chk("out_ctl", 64'({out_wb_en, out_mem_r_en, out_mem_w_en}),
            64'({mq[0].wb_en, mq[0].mem_r_en, mq[0].mem_w_en}));
      end
`ifdef EX_MEM_FWD_EN
      begin
        bit fv;
        fv = (mq.size() != 0) && mq[0].wb_en && !mq[0].mem_r_en;
        chk("fwd_valid", 64'(fwd_valid), 64'(fv));
        if (fv) begin
          chk("fwd_dest",  64'(fwd_dest),  64'(mq[0].dest));
          chk("fwd_value", 64'(fwd_value), 64'(mq[0].alu_result));
        end
      end
`endif
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] res, input logic [3:0] dst);
    in_valid      = 1'b1;
    in_alu_result = res;
    in_st_val     = ~res;
    in_dest       = dst;
    in_wb_en      = 1'b1;
    in_mem_r_en   = 1'b0;
    in_mem_w_en   = res[0];
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst out_valid", 64'(out_valid), 64'd0);
    chk("rst in_ready",  64'(in_ready),  64'd1);
    chk("rst status",    64'(status),    64'd0);
    chk("rst payload",   64'(out_alu_result | out_st_val), 64'd0);
    rst_n = 1'b1;

    // Single entry, one-cycle latency
    out_ready = 1'b1;
    push(32'h0000_00AA, 4'd3);
    cyc();
    in_valid = 1'b0;
    chk("t1 valid", 64'(out_valid), 64'd1);
    chk("t1 result", 64'(out_alu_result), 64'h0000_00AA);
    chk("t1 dest", 64'(out_dest), 64'd3);
    cyc();
    chk("t1 drained", 64'(out_valid), 64'd0);

    // Back-pressure fills the skid entry
    out_ready = 1'b0;
    push(32'h11, 4'd1);
    cyc();
    chk("t2 ready after 1", 64'(in_ready), 64'd1);
    push(32'h22, 4'd2);
    cyc();
    in_valid = 1'b0;
    chk("t2 ready full", 64'(in_ready), 64'd0);
    chk("t2 head", 64'(out_alu_result), 64'h11);
    cyc();
    chk("t2 held", 64'(out_alu_result), 64'h11);
    out_ready = 1'b1;
    cyc();
    chk("t2 second", 64'(out_alu_result), 64'h22);
    chk("t2 second valid", 64'(out_valid), 64'd1);
    cyc();
    chk("t2 empty", 64'(out_valid), 64'd0);

    // Streaming: no bubbles
    for (int i = 0; i < 8; i++) begin
      push(32'h100 + i, 4'(i));
      cyc();
      chk("t3 ready", 64'(in_ready), 64'd1);
      chk("t3 result", 64'(out_alu_result), 64'h100 + 64'(i));
    end
    in_valid = 1'b0;
    cyc();

    // Status update only when s_en
    push(32'h5, 4'd7);
    in_s_en = 1'b1; in_flags = 4'b0110;
    cyc();
    chk("t4 status set", 64'(status), 64'b0110);
    in_s_en = 1'b0; in_flags = 4'b1111;
    cyc();
    chk("t4 status held", 64'(status), 64'b0110);
    in_valid = 1'b0;
    cyc();

    // Flush from FULL discards the concurrent entry and its flags
    out_ready = 1'b0;
    push(32'h33, 4'd4); cyc();
    push(32'h44, 4'd5); cyc();
    chk("t5 full", 64'(in_ready), 64'd0);
    flush = 1'b1; in_s_en = 1'b1; in_flags = 4'b1000;
    cyc();
    flush = 1'b0; in_s_en = 1'b0; in_valid = 1'b0;
    chk("t5 flushed valid", 64'(out_valid), 64'd0);
    chk("t5 flushed ready", 64'(in_ready), 64'd1);
    chk("t5 status kept", 64'(status), 64'b0110);
    cyc();
    chk("t5 stays empty", 64'(out_valid), 64'd0);

`ifdef EX_MEM_FWD_EN
    out_ready = 1'b1;
    push(32'h1234, 4'd5);
    cyc();
    chk("fwd valid", 64'(fwd_valid), 64'd1);
    chk("fwd dest", 64'(fwd_dest), 64'd5);
    chk("fwd value", 64'(fwd_value), 64'h1234);
    in_mem_r_en = 1'b1;
    cyc();
    in_valid = 1'b0; in_mem_r_en = 1'b0;
    chk("fwd load blocked", 64'(fwd_valid), 64'd0);
    cyc();
`endif

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      in_valid      = ($urandom_range(0, 3) != 0);
      out_ready     = ($urandom_range(0, 2) != 0);
      flush         = ($urandom_range(0, 19) == 0);
      in_alu_result = $urandom;
      in_st_val     = $urandom;
      in_dest       = 4'($urandom);
      in_wb_en      = 1'($urandom);
      in_mem_r_en   = 1'($urandom);
      in_mem_w_en   = 1'($urandom);
      in_s_en       = 1'($urandom);
      in_flags      = 4'($urandom);
      cyc();
    end
    flush = 1'b0; in_valid = 1'b0; in_s_en = 1'b0;

    // Async reset mid-stall
    out_ready = 1'b0;
    in_s_en = 1'b1; in_flags = 4'b1010;
    push(32'h55, 4'd9); cyc();
    in_s_en = 1'b0;
    push(32'h66, 4'd10); cyc();
    in_valid = 1'b0;
    chk("t6 pre full", 64'(in_ready), 64'd0);
    chk("t6 pre status", 64'(status), 64'b1010);
    #2 rst_n = 1'b0;
    #1;
    chk("t6 valid", 64'(out_valid), 64'd0);
    chk("t6 ready", 64'(in_ready), 64'd1);
    chk("t6 status", 64'(status), 64'd0);
    chk("t6 payload", 64'(out_alu_result | out_st_val), 64'd0);
    chk("t6 dest/ctl", 64'({out_dest, out_wb_en, out_mem_r_en, out_mem_w_en}), 64'd0);
`ifdef EX_MEM_FWD_EN
    chk("t6 fwd", 64'({fwd_valid, fwd_dest} | 64'(fwd_value)), 64'd0);
`endif
    cyc();
    rst_n = 1'b1;
    cyc();
    chk("t6 after", 64'(out_valid), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
